// File: rtl/persiana_ctrl_n.sv
// Multi-level blind controller: homes to level 0 after reset, then moves the motor between
// sensed levels on valid/ready targets, with retargeting, reversal dead-time and a sticky fault.
module persiana_ctrl_n #(
    parameter int unsigned N_POS       = 3,
    parameter int unsigned DEAD_CYC    = 4,
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter int unsigned PW          = $clog2(N_POS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [PW-1:0]    cmd_pos,
    output logic             cmd_ready,
    input  logic [N_POS-1:0] sens,
    output logic             subir,
    output logic             bajar,
    output logic [PW-1:0]    pos,
    output logic             busy,
    output logic             fault
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned DW = $clog2(DEAD_CYC + 1);

    typedef enum logic [2:0] {
        S_HOME,
        S_IDLE,
        S_UP,
        S_DOWN,
        S_DEAD,
        S_FAULT
    } state_t;

    state_t state_q, state_d;

    logic [N_POS-1:0] ss_meta_q, ss_q, ss_prev_q;
    logic [PW-1:0]    pos_q, pos_d;
    logic [PW-1:0]    target_q, target_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic             subir_q, subir_d;
    logic             bajar_q, bajar_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             fault_q, fault_d;

    logic [N_POS-1:0] rise;
    logic             multi;
    logic             new_lvl;
    logic [PW-1:0]    lvl_idx;
    logic             hit_tgt;
    logic             accept;
    logic             cmd_in_range;
    logic             beyond;
    logic             tmo;
    logic             dead_done;

    assign rise         = ss_q & ~ss_prev_q;
    assign new_lvl      = |rise;
    assign multi        = (ss_q & (ss_q - N_POS'(1))) != '0;
    assign accept       = cmd_valid & ready_q;
    assign cmd_in_range = 32'(cmd_pos) < N_POS;
    assign beyond       = (state_q == S_UP) ? (cmd_pos > pos_q) : (cmd_pos < pos_q);
    assign tmo          = (tcnt_q == TW'(TIMEOUT_CYC - 1)) && !new_lvl;
    assign dead_done    = dcnt_q == DW'(DEAD_CYC - 1);

    // Level index of the (single) active synchronised sensor, and whether it is the target.
    always_comb begin
        lvl_idx = '0;
        hit_tgt = 1'b0;
        for (int unsigned k = 0; k < N_POS; k++) begin
            if (ss_q[k]) begin
                lvl_idx = PW'(k);
                if (PW'(k) == target_q) hit_tgt = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_HOME;
        else       state_q <= state_d;
    end

    // Next state plus level/target/counter updates.
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        target_d = target_q;
        unique case (state_q)
            S_HOME: begin
                if (ss_q[0]) begin
                    pos_d    = '0;
                    target_d = '0;
                    state_d  = S_DEAD;
                end else if (tmo) begin
                    state_d = S_FAULT;
                end
            end
            S_IDLE: begin
                if (accept && cmd_in_range) begin
                    if (cmd_pos > pos_q) begin
                        target_d = cmd_pos;
                        state_d  = S_UP;
                    end else if (cmd_pos < pos_q) begin
                        target_d = cmd_pos;
                        state_d  = S_DOWN;
                    end
                end
            end
            S_UP, S_DOWN: begin
                if (new_lvl) pos_d = lvl_idx;
                // A target behind or at the current level is parked as pending and served after DEAD.
                if (accept && cmd_in_range) begin
                    target_d = cmd_pos;
                    if (!beyond) state_d = S_DEAD;
                end else if (hit_tgt) begin
                    state_d = S_DEAD;
                end else if (tmo) begin
                    state_d = S_FAULT;
                end
            end
            S_DEAD: begin
                if (dead_done) begin
                    if (target_q > pos_q)      state_d = S_UP;
                    else if (target_q < pos_q) state_d = S_DOWN;
                    else                       state_d = S_IDLE;
                end
            end
            S_FAULT: ;
            default: state_d = S_FAULT;
        endcase
        if (multi) state_d = S_FAULT;

        tcnt_d = '0;
        if (state_d == state_q && !new_lvl &&
            (state_q == S_HOME || state_q == S_UP || state_q == S_DOWN)) begin
            tcnt_d = tcnt_q + TW'(1);
        end

        dcnt_d = '0;
        if (state_q == S_DEAD && state_d == S_DEAD) dcnt_d = dcnt_q + DW'(1);
    end

    // Output decode from the next state so every output is registered with its state.
    always_comb begin
        subir_d = 1'b0;
        bajar_d = 1'b0;
        ready_d = 1'b0;
        busy_d  = 1'b1;
        fault_d = 1'b0;
        unique case (state_d)
            S_HOME:  bajar_d = 1'b1;
            S_IDLE:  begin ready_d = 1'b1; busy_d = 1'b0; end
            S_UP:    begin subir_d = 1'b1; ready_d = 1'b1; end
            S_DOWN:  begin bajar_d = 1'b1; ready_d = 1'b1; end
            S_DEAD:  ;
            S_FAULT: begin busy_d = 1'b0; fault_d = 1'b1; end
            default: ;
        endcase
    end

    // Sensor synchroniser, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ss_meta_q <= '0;
            ss_q      <= '0;
            ss_prev_q <= '0;
            pos_q     <= '0;
            target_q  <= '0;
            tcnt_q    <= '0;
            dcnt_q    <= '0;
            subir_q   <= 1'b0;
            bajar_q   <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            fault_q   <= 1'b0;
        end else begin
            ss_meta_q <= sens;
            ss_q      <= ss_meta_q;
            ss_prev_q <= ss_q;
            pos_q     <= pos_d;
            target_q  <= target_d;
            tcnt_q    <= tcnt_d;
            dcnt_q    <= dcnt_d;
            subir_q   <= subir_d;
            bajar_q   <= bajar_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            fault_q   <= fault_d;
        end
    end

    assign subir     = subir_q;
    assign bajar     = bajar_q;
    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign fault     = fault_q;
    assign pos       = pos_q;

endmodule

// File: tb/tb_persiana_ctrl_n.sv
// Bench for persiana_ctrl_n: hand sequences for homing/retarget/faults, then a table and random
// targets driven through a simple physical blind model, checked against expected level arithmetic.
module tb_persiana_ctrl_n;

    localparam int N    = 4;
    localparam int DEAD = 4;
    localparam int TO   = 50;
    localparam int PW   = 3;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [PW-1:0] cmd_pos   = '0;
    logic          cmd_ready;
    logic [N-1:0]  sens      = '0;
    logic          subir, bajar, busy, fault;
    logic [PW-1:0] pos;

    persiana_ctrl_n #(
        .N_POS(N), .DEAD_CYC(DEAD), .TIMEOUT_CYC(TO), .PW(PW)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_pos(cmd_pos),
        .cmd_ready(cmd_ready), .sens(sens), .subir(subir), .bajar(bajar),
        .pos(pos), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit seen_up, seen_dn;

    // Physical blind: sits on a level sensor, leaves it after 5 motor cycles, reaches the next after seg.
    bit plant_en = 1'b0;
    bit at;
    int lvl, nxt, run, seg;

    typedef struct {
        logic [PW-1:0] cmd;
        int            exp_pos;
        int            exp_dir;   // 0 none, 1 up, 2 down
    } vec_t;
    vec_t tbl [8];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic plant_step();
        if (subir ^ bajar) begin
            run++;
            if (at) begin
                if (run >= 5 && ((subir && lvl < N-1) || (bajar && lvl > 0))) begin
                    at  = 1'b0;
                    nxt = subir ? lvl + 1 : lvl - 1;
                    run = 0;
                    seg = $urandom_range(4, 12);
                end
            end else if (run >= seg) begin
                lvl = nxt;
                at  = 1'b1;
                run = 0;
            end
        end else begin
            run = 0;
        end
        sens = '0;
        if (at) sens[lvl] = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        seen_up = seen_up | subir;
        seen_dn = seen_dn | bajar;
        if (plant_en) plant_step();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 60 && !cmd_ready; k++) tick();
    endtask

    task automatic send(input logic [PW-1:0] c);
        cmd_valid = 1'b1;
        cmd_pos   = c;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic home_manual();
        reset = 1'b1;
        sens  = '0;
        ticks(2);
        reset = 1'b0;
        sens  = 4'b0001;
        wait_ready();
        chk1("home_ready", cmd_ready, 1'b1);
    endtask

    // One target request in plant mode, judged on outcome: final level, direction, levels passed, dead-time.
    task automatic do_move(input logic [PW-1:0] c, input int exp_pos, input int exp_dir, input int old_pos);
        bit up_s = 1'b0, dn_s = 1'b0, both = 1'b0, moved = 1'b0, done = 1'b0;
        int steps = 0, dead = 0, exp_steps;
        logic [PW-1:0] lastp;
        wait_ready();
        lastp = pos;
        send(c);
        for (int k = 0; k < 1000 && !done; k++) begin
            if (subir && bajar) both = 1'b1;
            if (subir) up_s = 1'b1;
            if (bajar) dn_s = 1'b1;
            if (subir || bajar) moved = 1'b1;
            else if (moved && busy && !cmd_ready) dead++;
            if (pos != lastp) begin
                steps++;
                lastp = pos;
            end
            if (!busy && cmd_ready) done = 1'b1;
            else tick();
        end
        exp_steps = (exp_pos > old_pos) ? exp_pos - old_pos : old_pos - exp_pos;
        chk1("mv_done", done, 1'b1);
        chkn("mv_pos", int'(pos), exp_pos);
        chkn("mv_dir", int'({dn_s, up_s}), exp_dir);
        chk1("mv_both_low", both, 1'b0);
        chkn("mv_levels", steps, exp_steps);
        if (exp_dir != 0) chkn("mv_dead", dead, DEAD);
        chk1("mv_nofault", fault, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        int mpos, c, e, d;

        // Reset values and homing.
        reset = 1'b1;
        ticks(3);
        chk1("rst_subir", subir, 1'b0);
        chk1("rst_bajar", bajar, 1'b0);
        chk1("rst_ready", cmd_ready, 1'b0);
        chk1("rst_busy", busy, 1'b1);
        chk1("rst_fault", fault, 1'b0);
        chkn("rst_pos", int'(pos), 0);
        reset = 1'b0;
        ticks(20);
        chk1("home_bajar", bajar, 1'b1);
        chk1("home_subir", subir, 1'b0);
        sens = 4'b0001;
        ticks(2);
        chk1("home_bajar_hold", bajar, 1'b1);
        tick();
        chk1("home_bajar_off", bajar, 1'b0);
        ticks(DEAD - 1);
        chk1("home_dead_ready", cmd_ready, 1'b0);
        tick();
        chk1("home_ready_on", cmd_ready, 1'b1);
        chkn("home_pos", int'(pos), 0);
        chk1("home_idle", busy, 1'b0);

        // Normal move 0 -> 3 with sensors pulsed.
        seen_up = 1'b0; seen_dn = 1'b0;
        send(3'd3);
        tick();
        chk1("mv_subir_on", subir, 1'b1);
        sens = 4'b0000; ticks(3); sens = 4'b0010; ticks(3);
        chkn("mv_pos1", int'(pos), 1);
        sens = 4'b0000; ticks(3); sens = 4'b0100; ticks(3);
        chkn("mv_pos2", int'(pos), 2);
        sens = 4'b0000; ticks(3); sens = 4'b1000; ticks(2);
        chk1("mv_subir_hold", subir, 1'b1);
        tick();
        chk1("mv_subir_off", subir, 1'b0);
        chkn("mv_pos3", int'(pos), 3);
        chk1("mv_no_bajar", seen_dn, 1'b0);
        ticks(DEAD);
        chk1("mv_ready_back", cmd_ready, 1'b1);

        // Retarget: 0 -> 3, reversed at level 1.
        home_manual();
        send(3'd3);
        sens = 4'b0000; ticks(3); sens = 4'b0010; ticks(3);
        chkn("rt_pos1", int'(pos), 1);
        chk1("rt_subir", subir, 1'b1);
        send(3'd0);
        chk1("rt_subir_off", subir, 1'b0);
        seen_up = 1'b0; seen_dn = 1'b0;
        ticks(DEAD - 1);
        chk1("rt_dead_quiet", seen_up | seen_dn, 1'b0);
        tick();
        chk1("rt_bajar_on", bajar, 1'b1);
        sens = 4'b0000; ticks(3); sens = 4'b0001; ticks(2);
        chk1("rt_bajar_hold", bajar, 1'b1);
        tick();
        chk1("rt_bajar_off", bajar, 1'b0);
        chkn("rt_pos0", int'(pos), 0);

        // Extend: 0 -> 1 becomes 0 -> 3 before reaching level 1.
        wait_ready();
        send(3'd1);
        sens = 4'b0000; ticks(2);
        chk1("ext_ready_moving", cmd_ready, 1'b1);
        send(3'd3);
        sens = 4'b0010; ticks(3);
        chkn("ext_pos1", int'(pos), 1);
        ticks(3);
        chk1("ext_no_stop", subir, 1'b1);
        sens = 4'b0000; ticks(2); sens = 4'b0100; ticks(3);
        sens = 4'b0000; ticks(2); sens = 4'b1000; ticks(3);
        chk1("ext_stop", subir, 1'b0);
        chkn("ext_pos3", int'(pos), 3);
        ticks(DEAD);

        // Drops in IDLE: current level and out-of-range.
        seen_up = 1'b0; seen_dn = 1'b0;
        send(3'd3);
        chk1("drop_same_ready", cmd_ready, 1'b1);
        chk1("drop_same_idle", busy, 1'b0);
        ticks(4);
        send(3'd4);
        chk1("drop_oor_ready", cmd_ready, 1'b1);
        ticks(4);
        chk1("drop_no_motor", seen_up | seen_dn, 1'b0);
        chkn("drop_pos", int'(pos), 3);

        // Reset mid-travel drops the motor without a clock edge.
        send(3'd1);
        tick();
        chk1("rst_mid_bajar_on", bajar, 1'b1);
        reset = 1'b1;
        #2;
        chk1("rst_async_bajar", bajar, 1'b0);
        chk1("rst_async_busy", busy, 1'b1);

        // Travel timeout.
        home_manual();
        send(3'd2);
        ticks(TO - 1);
        chk1("tmo_not_yet", fault, 1'b0);
        chk1("tmo_subir", subir, 1'b1);
        tick();
        chk1("tmo_fault", fault, 1'b1);
        chk1("tmo_subir_off", subir, 1'b0);
        sens = 4'b0010; cmd_valid = 1'b1; cmd_pos = 3'd0;
        ticks(10);
        cmd_valid = 1'b0;
        chk1("tmo_sticky", fault, 1'b1);
        chk1("tmo_sticky_motor", subir | bajar, 1'b0);
        chk1("tmo_sticky_ready", cmd_ready, 1'b0);
        reset = 1'b1;
        tick();
        chk1("tmo_cleared", fault, 1'b0);

        // Two sensors at once.
        home_manual();
        sens = 4'b0101;
        ticks(2);
        chk1("sf_not_yet", fault, 1'b0);
        tick();
        chk1("sf_fault", fault, 1'b1);
        sens = 4'b0001;
        ticks(5);
        chk1("sf_sticky", fault, 1'b1);
        reset = 1'b1;
        tick();
        chk1("sf_cleared", fault, 1'b0);
        chk1("sf_busy_rst", busy, 1'b1);

        // Plant-driven phase: homing from a random level, then table and random targets.
        lvl = $urandom_range(0, N-1);
        at = 1'b1; run = 0; seg = 8;
        sens = '0; sens[lvl] = 1'b1;
        plant_en = 1'b1;
        ticks(2);
        reset = 1'b0;
        for (int k = 0; k < 400 && !cmd_ready; k++) tick();
        chk1("plant_home_ready", cmd_ready, 1'b1);
        chkn("plant_home_pos", int'(pos), 0);

        tbl[0] = '{3'd2, 2, 1};
        tbl[1] = '{3'd2, 2, 0};
        tbl[2] = '{3'd4, 2, 0};
        tbl[3] = '{3'd0, 0, 2};
        tbl[4] = '{3'd3, 3, 1};
        tbl[5] = '{3'd1, 1, 2};
        tbl[6] = '{3'd7, 1, 0};
        tbl[7] = '{3'd3, 3, 1};
        mpos = 0;
        for (int i = 0; i < 8; i++) begin
            do_move(tbl[i].cmd, tbl[i].exp_pos, tbl[i].exp_dir, mpos);
            mpos = tbl[i].exp_pos;
        end

        for (int i = 0; i < 30; i++) begin
            c = $urandom_range(0, 7);
            e = (c < N) ? c : mpos;
            d = (e > mpos) ? 1 : (e < mpos) ? 2 : 0;
            do_move(PW'(c), e, d, mpos);
            mpos = e;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
